// File: rtl/ex_wb_forward.sv
// M/W pipeline tail: carries EX results through memory and writeback, drives the
// register-file and condition-bit write ports, and resolves operand forwarding and load-use hazards.
module ex_wb_forward #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          ex_regwrite_i,
  input  logic          ex_write_data_control_i,
  input  logic          ex_CBwrite_i,
  input  logic          ex_memread_i,
  input  logic          ex_memwrite_i,
  input  logic [AW-1:0] ex_write_addr_i,
  input  logic [AW-1:0] ex_rs_addr_i,
  input  logic [AW-1:0] ex_rt_addr_i,
  input  logic [DW-1:0] ex_alu_result_i,
  input  logic          ex_cb_i,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          stall_i,
  input  logic          flush_i,
  output logic          rf_we_o,
  output logic [AW-1:0] rf_waddr_o,
  output logic [DW-1:0] rf_wdata_o,
  output logic          cb_we_o,
  output logic          cb_o,
  output logic [1:0]    fwd_rs_sel_o,
  output logic [1:0]    fwd_rt_sel_o,
  output logic [DW-1:0] fwd_m_data_o,
  output logic [DW-1:0] fwd_w_data_o,
  output logic          load_use_o
);

  typedef struct packed {
    logic          valid;
    logic          regwrite;
    logic          wdc;
    logic          cbwrite;
    logic          memread;
    logic          memwrite;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] data;
    logic          cb;
  } stage_t;

  stage_t m_r, w_r;
  stage_t m_next_s, w_next_s;
  logic   unused_s;

  // M beats W; a load still in M has no data yet, so it never forwards from M.
  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src, input stage_t m, input stage_t w);
    if (m.valid && m.regwrite && !m.wdc && (m.write_addr == src)) begin
      return 2'b01;
    end else if (w.valid && w.regwrite && (w.write_addr == src)) begin
      return 2'b10;
    end else begin
      return 2'b00;
    end
  endfunction

  // Next-state contents of M (from EX) and W (from M, load data merged in).
  always_comb begin
    m_next_s            = '0;
    m_next_s.valid      = ~flush_i;
    m_next_s.regwrite   = ex_regwrite_i;
    m_next_s.wdc        = ex_write_data_control_i;
    m_next_s.cbwrite    = ex_CBwrite_i;
    m_next_s.memread    = ex_memread_i;
    m_next_s.memwrite   = ex_memwrite_i;
    m_next_s.write_addr = ex_write_addr_i;
    m_next_s.data       = ex_alu_result_i;
    m_next_s.cb         = ex_cb_i;
    w_next_s            = m_r;
    if (m_r.wdc) begin
      w_next_s.data = mem_rdata_i;
    end else begin
      w_next_s.data = m_r.data;
    end
  end

  // Stage registers: reset clears everything, stall holds both stages.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      m_r <= '0;
      w_r <= '0;
    end else if (!stall_i) begin
      m_r <= m_next_s;
      w_r <= w_next_s;
    end else begin
      m_r <= m_r;
      w_r <= w_r;
    end
  end

  assign rf_we_o      = w_r.valid & w_r.regwrite & ~stall_i;
  assign rf_waddr_o   = w_r.write_addr;
  assign rf_wdata_o   = w_r.data;
  assign cb_we_o      = w_r.valid & w_r.cbwrite & ~stall_i;
  assign cb_o         = w_r.cb;
  assign fwd_rs_sel_o = fwd_sel(ex_rs_addr_i, m_r, w_r);
  assign fwd_rt_sel_o = fwd_sel(ex_rt_addr_i, m_r, w_r);
  assign fwd_m_data_o = m_r.data;
  assign fwd_w_data_o = w_r.data;
  assign load_use_o   = m_r.valid & m_r.memread & m_r.regwrite &
                        ((m_r.write_addr == ex_rs_addr_i) | (m_r.write_addr == ex_rt_addr_i));

  // Store flag and W-side memory controls are carried but intentionally unused.
  assign unused_s = m_r.memwrite ^ w_r.memwrite ^ w_r.memread ^ w_r.wdc;

endmodule
